imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Boot-time sequencer for the byte-addressed instruction memory. It accepts a program as a stream of 32-bit words from a host over a valid/ready handshake and drives the memory's load/store write port one word per cycle. It holds the memory's fetch `ready` low until the last word has landed, then releases the core. It sits between the host/test interface and the instruction memory, and owns that memory's `load`, `store` and `ready` inputs.

## Interface
- `MAX_WORDS`, default 256: capacity in words (1024 bytes / 4).
- `CNT_W`, default 9: width of word counters; must hold `MAX_WORDS`.
- `TIMEOUT`, default 1024: idle cycles allowed between accepted words during a load.
- `clk` in, 1: single clock; everything is on the rising edge.
- `rst` in, 1: reset, asynchronous, active-high.
- `start` in, 1: one-cycle request to begin a load session.
- `word_count` in, `CNT_W`: number of words in the session; sampled when `start` is accepted.
- `in_valid` in, 1: host word valid.
- `in_data` in, 32: host word, little-endian byte order into memory.
- `in_ready` out, 1: loader can accept a word this cycle.
- `mem_load` out, 1: write strobe to instruction memory; one cycle per word.
- `mem_store` out, 32: word being written.
- `mem_addr` out, 10: byte address of the word being written. Starts at 0 each session, +4 per word.
- `core_ready` out, 1: drives the memory's fetch-enable `ready`.
- `busy` out, 1: high in LOAD and SETTLE.
- `done` out, 1: one-cycle pulse when a session completes.
- `error` out, 1: sticky until the next accepted `start` or `rst`.
- `words_loaded` out, `CNT_W`: words written in the current or last session.

## Operation
- States: IDLE, LOAD, SETTLE, RUN, ERROR. Reset goes to IDLE.
- **IDLE, RUN, ERROR:** `start` is accepted.
  - If `word_count` is 0 or greater than `MAX_WORDS`: go to ERROR and set `error`. `core_ready` is 0.
  - Otherwise: go to LOAD. `remaining` is set to `word_count`; `mem_addr`, `words_loaded`, the idle timer and `error` are cleared; `core_ready` drops to 0.
- **LOAD:**
  - `in_ready = 1` while `remaining > 0`.
  - A transfer occurs on `in_valid && in_ready`. On that edge: `mem_store <= in_data`, `mem_load <= 1`, `remaining` decrements, `words_loaded` increments, and the idle timer clears.
  - `mem_addr` increments by 4 on the edge after each `mem_load` cycle, so it is valid during the strobe.
  - The transfer that brings `remaining` to 0 moves the state to SETTLE.
  - `start` in LOAD is ignored.
- **Timeout:** in LOAD, the idle timer counts cycles without a transfer. When it reaches `TIMEOUT`, go to ERROR and set `error`. `mem_load` is 0, partial contents are left in memory, and `core_ready` stays 0.
- **SETTLE:** one cycle, during which the final `mem_load` is asserted. Then go to RUN and pulse `done`.
- **RUN:** `core_ready = 1`. A new `start` reloads: `core_ready` falls on the edge that accepts `start`.
- **ERROR:** `core_ready = 0` and `in_ready = 0` until a valid `start`.
- **Widths:** `mem_addr` is 10 bits and wraps modulo 1024. Wrap cannot occur when `word_count <= MAX_WORDS`. `words_loaded` saturates at `MAX_WORDS`.

## Timing
- **Reset values:** state IDLE; `in_ready`, `mem_load`, `core_ready`, `busy`, `done`, `error` = 0; `mem_store`, `mem_addr`, `words_loaded` = 0. Asserting `rst` mid-session aborts immediately to these values.
- **Outputs:** `in_ready`, `busy` and `core_ready` decode from state/`remaining`. `mem_load`, `mem_store`, `mem_addr`, `done` and `error` are registered.
- **Session start:** `start` accepted at edge S → LOAD from S, so `in_ready` can be high in cycle S+1.
- **Write latency:** a word accepted at edge T is written with `mem_load = 1` in cycle T+1. That gives a maximum of 1 word/cycle with back-to-back `mem_load`.
- **Release:** last word accepted at edge N → SETTLE in cycle N+1 (final `mem_load`) → `core_ready = 1` and `done = 1` in cycle N+2.
- **Stalls:** `in_valid` low in LOAD leaves all counters unchanged except the idle timer. The host may hold `in_data` arbitrarily; no word is taken twice.
- **Timeout latency:** the idle timer reaching `TIMEOUT` at edge E → ERROR and `error = 1` from cycle E+1.

## Test plan
- **Normal load:** reset, `start` with `word_count = 4`, stream 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00 back-to-back.
  - Four consecutive `mem_load` pulses with `mem_addr` 0, 4, 8, 12.
  - `core_ready` and `done` rise exactly 2 cycles after the 4th accept; `words_loaded` = 4.
- **Host bubbles:** `word_count = 3` with `in_valid` toggling 1,0,0,1,0,1.
  - Exactly 3 `mem_load` pulses with the correct data; `in_ready` drops after the 3rd; no extra write.
- **Bad count:** `start` with `word_count = 0`, then with 257 → ERROR, `error = 1`, `core_ready = 0`, `in_ready = 0`, no `mem_load`.
- **Timeout:** `TIMEOUT = 8`, `word_count = 2`, send 1 word then idle 8 cycles → `error = 1`, state ERROR, `words_loaded` = 1. A subsequent valid `start` clears `error`.
- **Reload and reset:** from RUN, `start` with `word_count = 2` → `core_ready` drops on that edge; `mem_addr` restarts at 0; `done` pulses again.
- **Mid-load reset:** assert `rst` mid-load → all outputs at reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot-time loader for the instruction memory: streams host words into the
// memory write port, then releases the core's fetch-enable once the last word lands.
module imem_boot_loader #(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 9,
  parameter int TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             mem_load,
  output logic [31:0]      mem_store,
  output logic [9:0]       mem_addr,
  output logic             core_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  // The idle timer only has to hold TIMEOUT-1; the edge that would reach
  // TIMEOUT is the one that moves to ERROR.
  localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);

  logic [2:0]       state;
  logic [CNT_W-1:0] remaining;
  logic [TMR_W-1:0] idle_cnt;

  logic can_start;
  logic count_ok;
  logic xfer;
  logic last_xfer;

  assign in_ready   = (state == S_LOAD) && (remaining != '0);
  assign busy       = (state == S_LOAD) || (state == S_SETTLE);
  assign core_ready = (state == S_RUN);

  assign can_start = (state == S_IDLE) || (state == S_RUN) || (state == S_ERROR);
  assign count_ok  = (word_count != '0) && (word_count <= MAX_CNT);
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (remaining == CNT_W'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      remaining    <= '0;
      idle_cnt     <= '0;
      mem_load     <= 1'b0;
      mem_store    <= '0;
      mem_addr     <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_load <= 1'b0;
      done     <= 1'b0;

      // Address advances after the strobe so it is stable while mem_load is high.
      if (mem_load) begin
        mem_addr <= mem_addr + 10'd4;
      end

      case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (can_start && start) begin
            if (count_ok) begin
              state        <= S_LOAD;
              remaining    <= word_count;
              mem_addr     <= '0;
              words_loaded <= '0;
              idle_cnt     <= '0;
              error        <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (xfer) begin
            mem_store <= in_data;
            mem_load  <= 1'b1;
            remaining <= remaining - CNT_W'(1);
            idle_cnt  <= '0;
            if (words_loaded != MAX_CNT) begin
              words_loaded <= words_loaded + CNT_W'(1);
            end
            if (last_xfer) begin
              state <= S_SETTLE;
            end
          end else if (idle_cnt == TMR_LAST) begin
            state <= S_ERROR;
            error <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + TMR_W'(1);
          end
        end

        S_SETTLE: begin
          state <= S_RUN;
          done  <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus queues the expected writes and
// done pulses, a negedge monitor pops and compares them as the DUT emits them.
module tb_imem_boot_loader;

  localparam int CNT_W = 9;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] word_count;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             mem_load;
  logic [31:0]      mem_store;
  logic [9:0]       mem_addr;
  logic             core_ready;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] words_loaded;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  sess_idx = 0;
  int  sess_total = 0;
  wr_t mon_e;
  int  mon_d;

  imem_boot_loader #(
    .MAX_WORDS(256),
    .CNT_W    (CNT_W),
    .TIMEOUT  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .word_count  (word_count),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_load    (mem_load),
    .mem_store   (mem_store),
    .mem_addr    (mem_addr),
    .core_ready  (core_ready),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},     in_ready,     0);
    check({tag, "_mem_load"},     mem_load,     0);
    check({tag, "_core_ready"},   core_ready,   0);
    check({tag, "_busy"},         busy,         0);
    check({tag, "_done"},         done,         0);
    check({tag, "_error"},        error,        0);
    check({tag, "_mem_store"},    mem_store,    0);
    check({tag, "_mem_addr"},     mem_addr,     0);
    check({tag, "_words_loaded"}, words_loaded, 0);
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the accept edge.
  task automatic do_start(input int cnt);
    start      = 1'b1;
    word_count = CNT_W'(cnt);
    sess_idx   = 0;
    sess_total = cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    exp_wr.push_back('{addr: 10'(sess_idx * 4), data: d});
    sess_idx++;
    if (sess_idx == sess_total) exp_done.push_back(sess_total);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: every write strobe and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_load) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write addr=%0h data=%0h required=no write", mem_addr, mem_store);
        end else begin
          mon_e = exp_wr.pop_front();
          check("wr_addr", mem_addr, mon_e.addr);
          check("wr_data", mem_store, mon_e.data);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done words_loaded=%0d required=no done", words_loaded);
        end else begin
          mon_d = exp_done.pop_front();
          check("done_words", words_loaded, mon_d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  logic [31:0] bub_data [3];
  logic [5:0]  bub_pat;

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    word_count = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Normal load, back-to-back
    do_start(4);
    check("norm_in_ready", in_ready, 1);
    check("norm_busy", busy, 1);
    check("norm_core_ready_low", core_ready, 0);
    send_word(32'h11223344);
    send_word(32'h55667788);
    send_word(32'h99AABBCC);
    send_word(32'hDDEEFF00);
    check("norm_settle_in_ready", in_ready, 0);
    check("norm_settle_core_ready", core_ready, 0);
    check("norm_settle_done", done, 0);
    check("norm_settle_mem_load", mem_load, 1);
    @(negedge clk);
    check("norm_release_core_ready", core_ready, 1);
    check("norm_release_done", done, 1);
    check("norm_words_loaded", words_loaded, 4);
    check("norm_release_busy", busy, 0);
    @(negedge clk);
    check("norm_done_one_cycle", done, 0);

    // Host bubbles, reload from RUN
    bub_data[0] = 32'hA0A1A2A3;
    bub_data[1] = 32'hB0B1B2B3;
    bub_data[2] = 32'hC0C1C2C3;
    bub_pat     = 6'b101001;
    check("bub_core_ready_before", core_ready, 1);
    do_start(3);
    check("bub_core_ready_fall", core_ready, 0);
    check("bub_addr_restart", mem_addr, 0);
    for (int i = 0, k = 0; i < 6; i++) begin
      if (bub_pat[i]) begin
        send_word(bub_data[k]);
        k++;
      end else begin
        in_valid = 1'b0;
        in_data  = 32'hDEADBEEF;
        @(negedge clk);
      end
    end
    check("bub_in_ready_drop", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 32'hBAD0BAD0;
    @(negedge clk);
    check("bub_core_ready", core_ready, 1);
    check("bub_words_loaded", words_loaded, 3);
    @(negedge clk);
    check("bub_run_in_ready", in_ready, 0);
    in_valid = 1'b0;

    // Bad counts
    do_start(0);
    check("bad0_error", error, 1);
    check("bad0_core_ready", core_ready, 0);
    check("bad0_in_ready", in_ready, 0);
    in_valid = 1'b1;
    @(negedge clk);
    check("bad0_mem_load", mem_load, 0);
    in_valid = 1'b0;
    do_start(257);
    check("bad257_error", error, 1);
    check("bad257_core_ready", core_ready, 0);
    check("bad257_in_ready", in_ready, 0);
    check("bad257_busy", busy, 0);

    // Timeout after one word
    do_start(2);
    check("to_error_cleared", error, 0);
    check("to_in_ready", in_ready, 1);
    send_word(32'h0BADF00D);
    for (int i = 0; i < 8; i++) begin
      check("to_still_loading", {error, busy}, 2'b01);
      @(negedge clk);
    end
    check("to_error", error, 1);
    check("to_busy", busy, 0);
    check("to_core_ready", core_ready, 0);
    check("to_in_ready_low", in_ready, 0);
    check("to_words_loaded", words_loaded, 1);

    // Recovery from ERROR, then reload from RUN
    do_start(2);
    check("rec_error_cleared", error, 0);
    send_word(32'h01234567);
    send_word(32'h89ABCDEF);
    @(negedge clk);
    check("rec_core_ready", core_ready, 1);
    check("rec_done", done, 1);
    do_start(2);
    check("rel_core_ready_fall", core_ready, 0);
    check("rel_addr_restart", mem_addr, 0);
    check("rel_words_cleared", words_loaded, 0);
    send_word(32'hCAFEF00D);
    send_word(32'hFEEDFACE);
    @(negedge clk);
    check("rel_core_ready", core_ready, 1);
    check("rel_done", done, 1);
    check("rel_words_loaded", words_loaded, 2);
    @(negedge clk);

    // Mid-load asynchronous reset
    do_start(4);
    send_word(32'h13579BDF);
    send_word(32'h2468ACE0);
    #2 rst = 1'b1;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 0);
    check("post_rst_mem_load", mem_load, 0);

    check("wr_queue_empty", exp_wr.size(), 0);
    check("done_queue_empty", exp_done.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
